// File: rtl/muldiv_pkg.sv
// Shared op-class encodings and FSM state type
// for the parametrised multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MTLO = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MULT = 3'b100;
    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam logic [2:0] OP_MADD = 3'b110;
    localparam logic [2:0] OP_MSUB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_ACC
    } state_t;

endpackage

// File: rtl/muldiv_gen_if.sv
// Operand/result bundle between the EX stage
// and the multiply/divide unit.
interface muldiv_gen_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             abort;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             div_by_zero;

    modport master (
        output a, b, op, abort,
        input  hi, lo, busy, div_by_zero
    );
    modport slave (
        input  a, b, op, abort,
        output hi, lo, busy, div_by_zero
    );
endinterface

// File: rtl/muldiv_div_iter.sv
// Restoring divider on magnitudes, DIV_BITS
// quotient bits retired per cycle.
module muldiv_div_iter #(
    parameter int WIDTH    = 32,
    parameter int DIV_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done
);
    localparam int N  = WIDTH / DIV_BITS;
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH:0]   t;
    logic             ge;

    // q doubles as the dividend shift register
    always_comb begin
        rem_n = r;
        quo_n = q;
        t     = '0;
        ge    = 1'b0;
        for (int i = 0; i < DIV_BITS; i++) begin
            t  = {rem_n, quo_n[WIDTH-1]};
            ge = (t >= {1'b0, dvs});
            rem_n = ge ? (t[WIDTH-1:0] - dvs) : t[WIDTH-1:0];
            quo_n = {quo_n[WIDTH-2:0], ge};
        end
    end

    assign done = run && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
            q   <= '0;
            r   <= '0;
            dvs <= '0;
        end else if (cancel) begin
            run <= 1'b0;
        end else if (start) begin
            q   <= dividend;
            r   <= '0;
            dvs <= divisor;
            cnt <= CW'(N);
            run <= 1'b1;
        end else if (run) begin
            if (cnt != '0) begin
                q   <= quo_n;
                r   <= rem_n;
                cnt <= cnt - 1'b1;
            end else begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_gen.sv
// HI/LO multiply/divide unit: pipelined multiplier,
// iterative divider, MADD/MSUB accumulate, abort.
module muldiv_gen
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input logic         clk,
    input logic         rst,
    muldiv_gen_if.slave bus
);
    localparam logic [2:0] LAST = 3'(MUL_STAGES - 1);

    state_t state, state_n;

    logic [2:0]         cls;
    logic               sx;
    logic               issue, is_mul, is_div;
    logic [2:0]         cnt;
    logic [2*WIDTH-1:0] pipe [MUL_STAGES];
    logic [2*WIDTH-1:0] ax, bx, prod, hilo;
    logic [WIDTH-1:0]   hi_q, lo_q, a_lat;
    logic [WIDTH-1:0]   a_mag, b_mag, dq, dr;
    logic               acc_op, sub_op, dz_pend;
    logic               q_neg, r_neg, dz_q;
    logic               dv_start, dv_done, cancel;
    logic               wr_mul, wr_acc, wr_div, wr_dz;
    logic               shift, busy;

    assign cls = bus.op[3:1];
    assign sx  = ~bus.op[0];

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        unique case (1'b1)
            (cls == OP_MULT),
            (cls == OP_MADD),
            (cls == OP_MSUB): is_mul = 1'b1;
            (cls == OP_DIV):  is_div = 1'b1;
            default: ;
        endcase
    end

    assign issue = (state == ST_IDLE) & ~bus.abort &
                   (cls[2:1] != OP_NOP[2:1]);

    // Truncated 2W product equals the (W+1)-bit extended product mod 2^2W
    assign ax   = {{WIDTH{sx & bus.a[WIDTH-1]}}, bus.a};
    assign bx   = {{WIDTH{sx & bus.b[WIDTH-1]}}, bus.b};
    assign prod = ax * bx;
    assign hilo = {hi_q, lo_q};

    assign a_mag = (sx & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag = (sx & bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign cancel   = bus.abort & (state != ST_IDLE);
    assign dv_start = issue & is_div & (bus.b != '0);

    muldiv_div_iter #(
        .WIDTH    (WIDTH),
        .DIV_BITS (DIV_BITS)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (dv_start),
        .cancel   (cancel),
        .dividend (a_mag),
        .divisor  (b_mag),
        .q        (dq),
        .r        (dr),
        .done     (dv_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        shift   = 1'b0;
        wr_mul  = 1'b0;
        wr_acc  = 1'b0;
        wr_div  = 1'b0;
        wr_dz   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (issue && is_mul) begin
                    state_n = ST_MUL;
                    shift   = 1'b1;
                end else if (issue && is_div) begin
                    state_n = ST_DIV;
                end
            end
            ST_MUL: begin
                busy = acc_op | (cnt != LAST);
                if (cnt != LAST) begin
                    shift = 1'b1;
                end else if (acc_op) begin
                    state_n = ST_ACC;
                end else begin
                    wr_mul  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_ACC: begin
                wr_acc  = 1'b1;
                state_n = ST_IDLE;
            end
            ST_DIV: begin
                busy = ~(dz_pend | dv_done);
                if (dz_pend) begin
                    wr_dz   = 1'b1;
                    state_n = ST_IDLE;
                end else if (dv_done) begin
                    wr_div  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (cancel) begin
            state_n = ST_IDLE;
            shift   = 1'b0;
            wr_mul  = 1'b0;
            wr_acc  = 1'b0;
            wr_div  = 1'b0;
            wr_dz   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc_op  <= 1'b0;
            sub_op  <= 1'b0;
            dz_pend <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            a_lat   <= '0;
        end else if (issue) begin
            cnt     <= '0;
            acc_op  <= (cls == OP_MADD) | (cls == OP_MSUB);
            sub_op  <= (cls == OP_MSUB);
            dz_pend <= is_div & (bus.b == '0);
            q_neg   <= sx & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg   <= sx & bus.a[WIDTH-1];
            a_lat   <= bus.a;
        end else if (state == ST_MUL && cnt != LAST) begin
            cnt <= cnt + 3'd1;
        end
    end

    // Final stage holds while ACC consumes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
        end else if (shift) begin
            pipe[0] <= prod;
            for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b0;
        end else begin
            dz_q <= wr_dz;
            if (issue && cls == OP_MTLO) begin
                lo_q <= bus.a;
            end else if (issue && cls == OP_MTHI) begin
                hi_q <= bus.a;
            end else if (wr_mul) begin
                {hi_q, lo_q} <= pipe[MUL_STAGES-1];
            end else if (wr_acc) begin
                {hi_q, lo_q} <= sub_op ? hilo - pipe[MUL_STAGES-1]
                                       : hilo + pipe[MUL_STAGES-1];
            end else if (wr_div) begin
                lo_q <= q_neg ? -dq : dq;
                hi_q <= r_neg ? -dr : dr;
            end else if (wr_dz) begin
                lo_q <= '1;
                hi_q <= a_lat;
            end
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy;
    assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_gen.sv
// Bench for muldiv_gen: two configurations driven in lockstep,
// checked against an arithmetic reference model.
module tb_muldiv_gen;
    localparam int W = 32;
    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_MTLO = 3'd2;
    localparam logic [2:0] C_MTHI = 3'd3;
    localparam logic [2:0] C_MULT = 3'd4;
    localparam logic [2:0] C_DIV  = 3'd5;
    localparam logic [2:0] C_MADD = 3'd6;
    localparam logic [2:0] C_MSUB = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_gen_if #(.WIDTH(W)) bus0 ();
    muldiv_gen_if #(.WIDTH(W)) bus1 ();

    muldiv_gen #(.WIDTH(W), .MUL_STAGES(2), .DIV_BITS(1)) u0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );
    muldiv_gen #(.WIDTH(W), .MUL_STAGES(3), .DIV_BITS(2)) u1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] mh = '0;
    logic [W-1:0] ml = '0;

    function automatic int stages(input int d);
        return (d == 0) ? 2 : 3;
    endfunction
    function automatic int iters(input int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic logic [W-1:0] get_hi(input int d);
        return (d == 0) ? bus0.hi : bus1.hi;
    endfunction
    function automatic logic [W-1:0] get_lo(input int d);
        return (d == 0) ? bus0.lo : bus1.lo;
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 0) ? bus0.busy : bus1.busy;
    endfunction
    function automatic logic get_dz(input int d);
        return (d == 0) ? bus0.div_by_zero : bus1.div_by_zero;
    endfunction

    // Edge that writes HI/LO, counting the issue edge as 0
    function automatic int wr_edge(input int d, input logic [2:0] c, input bit dz);
        case (c)
            C_MULT: return stages(d);
            C_MADD, C_MSUB: return stages(d) + 1;
            C_DIV: return dz ? 1 : iters(d) + 1;
            default: return 0;
        endcase
    endfunction
    function automatic int busy_last(input int d, input logic [2:0] c, input bit dz);
        case (c)
            C_MULT: return stages(d) - 1;
            C_MADD, C_MSUB: return stages(d);
            C_DIV: return dz ? 0 : iters(d);
            default: return 0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ab);
        bus0.op = op; bus0.a = a; bus0.b = b; bus0.abort = ab;
        bus1.op = op; bus1.a = a; bus1.b = b; bus1.abort = ab;
    endtask

    task automatic model(input logic [2:0] c, input logic u,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] nh, output logic [W-1:0] nl,
                         output bit dz);
        longint pa, pb, qq, rr;
        logic [63:0] p, hl;
        pa = u ? longint'({32'b0, a}) : longint'($signed(a));
        pb = u ? longint'({32'b0, b}) : longint'($signed(b));
        p  = pa * pb;
        hl = {mh, ml};
        nh = mh; nl = ml; dz = 1'b0;
        case (c)
            C_MTLO: nl = a;
            C_MTHI: nh = a;
            C_MULT: {nh, nl} = p;
            C_MADD: {nh, nl} = hl + p;
            C_MSUB: {nh, nl} = hl - p;
            C_DIV: begin
                if (b == '0) begin
                    nl = '1; nh = a; dz = 1'b1;
                end else begin
                    qq = pa / pb;
                    rr = pa % pb;
                    nl = qq[31:0];
                    nh = rr[31:0];
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] c, input logic u,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] nh, nl, eh, el;
        bit dz;
        int we [2];
        int bl [2];
        int mx;
        logic eb, edz;
        model(c, u, a, b, nh, nl, dz);
        for (int d = 0; d < 2; d++) begin
            we[d] = wr_edge(d, c, dz);
            bl[d] = busy_last(d, c, dz);
        end
        mx = (we[0] > we[1]) ? we[0] : we[1];
        drive({c, u}, a, b, 1'b0);
        for (int cy = 1; cy <= mx + 1; cy++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                eb = (cy <= bl[d]);
                n_chk++;
                if (get_busy(d) !== eb) begin
                    n_fail++;
                    $display("FAIL busy op%0d dut%0d cyc%0d: got %b want %b",
                             c, d, cy, get_busy(d), eb);
                end
                eh = (cy > we[d]) ? nh : mh;
                el = (cy > we[d]) ? nl : ml;
                n_chk++;
                if (get_hi(d) !== eh || get_lo(d) !== el) begin
                    n_fail++;
                    $display("FAIL hilo op%0d dut%0d cyc%0d: got %h_%h want %h_%h",
                             c, d, cy, get_hi(d), get_lo(d), eh, el);
                end
                edz = dz && (cy == 2);
                n_chk++;
                if (get_dz(d) !== edz) begin
                    n_fail++;
                    $display("FAIL dz op%0d dut%0d cyc%0d: got %b want %b",
                             c, d, cy, get_dz(d), edz);
                end
            end
            drive({C_NOP, 1'b0}, $urandom, $urandom, 1'b0);
        end
        mh = nh;
        ml = nl;
    endtask

    task automatic check_hilo(input string tag, input logic [W-1:0] eh,
                              input logic [W-1:0] el);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (get_hi(d) !== eh || get_lo(d) !== el) begin
                n_fail++;
                $display("FAIL %s dut%0d: got %h_%h want %h_%h",
                         tag, d, get_hi(d), get_lo(d), eh, el);
            end
        end
    endtask

    task automatic test_reset;
        drive({C_NOP, 1'b0}, '0, '0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (get_hi(d) !== '0 || get_lo(d) !== '0 ||
                get_busy(d) !== 1'b0 || get_dz(d) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h %h %b %b want 0 0 0 0",
                         d, get_hi(d), get_lo(d), get_busy(d), get_dz(d));
            end
        end
        rst = 1'b0;
        mh = '0;
        ml = '0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        run_op(C_MULT, 1'b0, 32'hFFFF_FFFE, 32'd3);
        check_hilo("mult_s", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op(C_MTLO, 1'b0, 32'd0, $urandom);
        run_op(C_MTHI, 1'b0, 32'd0, $urandom);
        check_hilo("mt_zero", 32'd0, 32'd0);
        run_op(C_MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(C_MADD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_hilo("maddu", 32'hFFFF_FFFC, 32'h0000_0002);
        run_op(C_MSUB, 1'b0, 32'hFFFF_FFF0, 32'd5);
        run_op(C_DIV, 1'b0, -32'sd7, 32'd2);
        check_hilo("div_s", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(C_DIV, 1'b1, 32'h1234, 32'd0);
        check_hilo("divu_z", 32'h0000_1234, 32'hFFFF_FFFF);
        run_op(C_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        check_hilo("div_ovf", 32'd0, 32'h8000_0000);
        run_op(C_DIV, 1'b0, 32'hFFFF_FF00, 32'd0);
    endtask

    task automatic test_random;
        logic [2:0] c;
        logic u;
        logic [W-1:0] a, b;
        int r;
        for (int i = 0; i < 40; i++) begin
            c = 3'($urandom_range(0, 7));
            u = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            r = $urandom_range(0, 15);
            if (r == 0) b = '0;
            else if (r == 1) begin a = 32'h8000_0000; b = '1; end
            else if (r == 2) b = 32'($urandom_range(1, 9));
            run_op(c, u, a, b);
        end
    endtask

    task automatic test_abort;
        logic [W-1:0] oh;
        run_op(C_MTHI, 1'b0, 32'hCAFE_0001, '0);
        run_op(C_MTLO, 1'b0, 32'hCAFE_0002, '0);
        oh = mh;
        drive({C_DIV, 1'b0}, 32'd100, 32'd7, 1'b0);
        for (int cy = 1; cy <= 7; cy++) begin
            @(negedge clk);
            if (cy == 5) begin
                for (int d = 0; d < 2; d++) begin
                    n_chk++;
                    if (get_busy(d) !== 1'b1) begin
                        n_fail++;
                        $display("FAIL abort_busy5 dut%0d: got %b want 1", d, get_busy(d));
                    end
                end
                drive({C_NOP, 1'b0}, $urandom, $urandom, 1'b1);
            end else if (cy == 6) begin
                for (int d = 0; d < 2; d++) begin
                    n_chk++;
                    if (get_busy(d) !== 1'b0) begin
                        n_fail++;
                        $display("FAIL abort_busy6 dut%0d: got %b want 0", d, get_busy(d));
                    end
                end
                drive({C_MTLO, 1'b0}, 32'h55, $urandom, 1'b0);
            end else begin
                drive({C_NOP, 1'b0}, $urandom, $urandom, 1'b0);
            end
        end
        ml = 32'h55;
        check_hilo("abort_mtlo", oh, 32'h55);
        repeat (40) @(negedge clk);
        check_hilo("abort_quiet", oh, 32'h55);
        drive({C_MADD, 1'b0}, 32'd9, 32'd9, 1'b0);
        @(negedge clk);
        drive({C_NOP, 1'b0}, '0, '0, 1'b1);
        @(negedge clk);
        drive({C_NOP, 1'b0}, '0, '0, 1'b0);
        repeat (6) @(negedge clk);
        check_hilo("abort_madd", oh, 32'h55);
    endtask

    task automatic test_ignore_rst;
        drive({C_DIV, 1'b0}, 32'd1000, 32'd7, 1'b0);
        for (int cy = 1; cy <= 40; cy++) begin
            @(negedge clk);
            if (cy == 3) begin
                for (int d = 0; d < 2; d++) begin
                    n_chk++;
                    if (get_busy(d) !== 1'b1) begin
                        n_fail++;
                        $display("FAIL ignore_busy dut%0d: got %b want 1", d, get_busy(d));
                    end
                end
                drive({C_MTHI, 1'b0}, 32'hDEAD, '0, 1'b0);
            end else begin
                drive({C_NOP, 1'b0}, $urandom, $urandom, 1'b0);
            end
        end
        mh = 32'd6;
        ml = 32'd142;
        check_hilo("ignore_mthi", 32'd6, 32'd142);
        drive({C_DIV, 1'b1}, 32'hFFFF_0000, 32'd3, 1'b0);
        for (int cy = 1; cy <= 9; cy++) begin
            @(negedge clk);
            drive({C_NOP, 1'b0}, $urandom, $urandom, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (get_hi(d) !== '0 || get_lo(d) !== '0 || get_busy(d) !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_rst dut%0d: got %h %h %b want 0 0 0",
                         d, get_hi(d), get_lo(d), get_busy(d));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        mh = '0;
        ml = '0;
        run_op(C_MULT, 1'b0, 32'd12345, -32'sd3);
    endtask

    initial begin
        drive({C_NOP, 1'b0}, '0, '0, 1'b0);
        test_reset;
        test_directed;
        test_random;
        test_abort;
        test_ignore_rst;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
